// File: rtl/fmul_share_arbiter.sv
`timescale 1ns/1ps
// Round-robin sharing of one pipelined f_mult among N_REQ requesters: registered issue,
// tag pipeline aligned to the multiplier latency, sticky flag on tag/result misalignment.
module fmul_share_arbiter #(
  parameter int N_REQ        = 4,
  parameter int FLEN         = 64,
  parameter int MULT_LATENCY = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_vld,
  input  logic [N_REQ*FLEN-1:0]   req_a,
  input  logic [N_REQ*FLEN-1:0]   req_b,
  output logic [N_REQ-1:0]        req_rdy,
  output logic [FLEN-1:0]         mul_a,
  output logic [FLEN-1:0]         mul_b,
  output logic                    mul_up_valid,
  input  logic [FLEN-1:0]         mul_res,
  input  logic                    mul_down_valid,
  output logic [N_REQ-1:0]        rsp_vld,
  output logic [FLEN-1:0]         rsp_data,
  output logic                    idle,
  output logic                    err
);
  localparam int IW = $clog2(N_REQ);
  localparam int L  = MULT_LATENCY;

  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    gnt_idx;
  logic [IW-1:0]    cand_idx;
  logic             gnt_found;
  logic [N_REQ-1:0] gnt_oh;
  int               cand;

  logic             mul_up_valid_q, mul_up_valid_d;
  logic [FLEN-1:0]  mul_a_q, mul_a_d;
  logic [FLEN-1:0]  mul_b_q, mul_b_d;
  logic [IW-1:0]    issue_idx_q, issue_idx_d;

  logic [L-1:0]     tag_vld_q, tag_vld_d;
  logic [IW-1:0]    tag_idx_q [L];
  logic [IW-1:0]    tag_idx_d [L];

  logic             err_q, err_d;

  // Search starts at ptr and wraps; grants are suppressed while reset is held.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand     = (int'(ptr_q) + k) % N_REQ;
      cand_idx = IW'(cand);
      if (!gnt_found && req_vld[cand_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
    if (!rst) gnt_found = 1'b0;
    gnt_oh = '0;
    if (gnt_found) gnt_oh[gnt_idx] = 1'b1;
  end

  always_comb begin
    ptr_d          = ptr_q;
    mul_up_valid_d = gnt_found;
    mul_a_d        = mul_a_q;
    mul_b_d        = mul_b_q;
    issue_idx_d    = issue_idx_q;
    if (gnt_found) begin
      ptr_d       = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      mul_a_d     = req_a[gnt_idx*FLEN +: FLEN];
      mul_b_d     = req_b[gnt_idx*FLEN +: FLEN];
      issue_idx_d = gnt_idx;
    end
  end

  // Stage 0 captures the issue cycle, so the last stage lines up with down_valid.
  always_comb begin
    tag_vld_d[0] = mul_up_valid_q;
    tag_idx_d[0] = issue_idx_q;
    for (int k = 1; k < L; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_idx_d[k] = tag_idx_q[k-1];
    end
    err_d = err_q | (mul_down_valid != tag_vld_q[L-1]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q          <= '0;
      mul_up_valid_q <= 1'b0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
      issue_idx_q    <= '0;
      tag_vld_q      <= '0;
      for (int k = 0; k < L; k++) tag_idx_q[k] <= '0;
      err_q          <= 1'b0;
    end else begin
      ptr_q          <= ptr_d;
      mul_up_valid_q <= mul_up_valid_d;
      mul_a_q        <= mul_a_d;
      mul_b_q        <= mul_b_d;
      issue_idx_q    <= issue_idx_d;
      tag_vld_q      <= tag_vld_d;
      for (int k = 0; k < L; k++) tag_idx_q[k] <= tag_idx_d[k];
      err_q          <= err_d;
    end
  end

  always_comb begin
    rsp_vld = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rsp_vld[i] = mul_down_valid & tag_vld_q[L-1] & (tag_idx_q[L-1] == IW'(i));
    end
  end

  assign req_rdy      = gnt_oh;
  assign mul_a        = mul_a_q;
  assign mul_b        = mul_b_q;
  assign mul_up_valid = mul_up_valid_q;
  assign rsp_data     = mul_res;
  assign idle         = !mul_up_valid_q && (tag_vld_q == '0);
  assign err          = err_q;

endmodule

// File: tb/tb_fmul_share_arbiter.sv
`timescale 1ns/1ps
// Directed bench for fmul_share_arbiter with a behavioural f_mult and an in-order scoreboard.
module tb_fmul_share_arbiter;
  localparam int N    = 4;
  localparam int FLEN = 64;
  localparam int L    = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_vld;
  logic [N*FLEN-1:0] req_a, req_b;
  logic [N-1:0]    req_rdy;
  logic [FLEN-1:0] mul_a, mul_b, mul_res;
  logic            mul_up_valid, mul_down_valid;
  logic [N-1:0]    rsp_vld;
  logic [FLEN-1:0] rsp_data;
  logic            idle, err;

  logic            force_dv;
  logic            model_rst_n;
  logic [L-1:0]    m_vld;
  logic [FLEN-1:0] m_res [L];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int c0;
  int q_idx[$];
  int q_cyc[$];
  logic [63:0] q_prod[$];

  always #5 clk = ~clk;

  fmul_share_arbiter #(.N_REQ(N), .FLEN(FLEN), .MULT_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_a(req_a), .req_b(req_b),
    .req_rdy(req_rdy), .mul_a(mul_a), .mul_b(mul_b), .mul_up_valid(mul_up_valid),
    .mul_res(mul_res), .mul_down_valid(mul_down_valid), .rsp_vld(rsp_vld),
    .rsp_data(rsp_data), .idle(idle), .err(err)
  );

  // Behavioural f_mult: fixed latency, ignores arbiter reset so stale results can appear.
  always_ff @(posedge clk or negedge model_rst_n) begin
    if (!model_rst_n) begin
      m_vld <= '0;
      for (int k = 0; k < L; k++) m_res[k] <= '0;
    end else begin
      m_vld[0] <= mul_up_valid;
      m_res[0] <= $realtobits($bitstoreal(mul_a) * $bitstoreal(mul_b));
      for (int k = 1; k < L; k++) begin
        m_vld[k] <= m_vld[k-1];
        m_res[k] <= m_res[k-1];
      end
    end
  end
  assign mul_down_valid = m_vld[L-1] | force_dv;
  assign mul_res        = m_res[L-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(negedge clk);
    cyc++;
  endtask

  task automatic set_op(input int i, input real a, input real b);
    req_a[i*FLEN +: FLEN] = $realtobits(a);
    req_b[i*FLEN +: FLEN] = $realtobits(b);
  endtask

  task automatic clear_sb();
    q_idx.delete();
    q_cyc.delete();
    q_prod.delete();
  endtask

  // Records accepts and checks each response for order, index, product and latency.
  task automatic mon();
    int idx;
    int c;
    logic [63:0] p;
    #1;
    if (rst) begin
      if (req_vld != '0) chk("rdy_onehot", 64'($countones(req_rdy) == 1), 64'h1);
      chk("rdy_subset", 64'(req_rdy & ~req_vld), 64'h0);
      for (int i = 0; i < N; i++) begin
        if (req_vld[i] && req_rdy[i]) begin
          q_idx.push_back(i);
          q_cyc.push_back(cyc);
          q_prod.push_back($realtobits($bitstoreal(req_a[i*FLEN +: FLEN]) *
                                       $bitstoreal(req_b[i*FLEN +: FLEN])));
        end
      end
      if (rsp_vld != '0) begin
        if (q_idx.size() == 0) begin
          chk("rsp_spurious", 64'(rsp_vld), 64'h0);
        end else begin
          idx = q_idx.pop_front();
          c   = q_cyc.pop_front();
          p   = q_prod.pop_front();
          chk("rsp_idx", 64'(rsp_vld), 64'(1) << idx);
          chk("rsp_data", rsp_data, p);
          chk("rsp_lat", 64'(cyc - c), 64'(1 + L));
        end
      end
    end
  endtask

  task automatic do_reset();
    adv();
    rst = 1'b0;
    #1;
    clear_sb();
    adv();
    rst = 1'b1;
    #1;
    chk("rst_err_clear", 64'(err), 64'h0);
  endtask

  initial begin
    rst = 1'b0; req_vld = '1; req_a = '0; req_b = '0;
    force_dv = 1'b0; model_rst_n = 1'b0;

    // Reset values with all requesters asking
    adv(); #1;
    chk("rst_rdy", 64'(req_rdy), 64'h0);
    chk("rst_rsp", 64'(rsp_vld), 64'h0);
    chk("rst_idle", 64'(idle), 64'h1);
    chk("rst_err", 64'(err), 64'h0);
    chk("rst_upv", 64'(mul_up_valid), 64'h0);
    chk("rst_mula", mul_a, 64'h0);
    model_rst_n = 1'b1; req_vld = '0;
    adv(); rst = 1'b1;

    // Single request 2.0 * 3.0
    adv();
    set_op(0, 2.0, 3.0); req_vld = 4'b0001;
    mon();
    chk("single_rdy", 64'(req_rdy), 64'h1);
    c0 = cyc;
    adv(); req_vld = '0; mon();
    chk("single_rdy_drop", 64'(req_rdy), 64'h0);
    chk("single_upv", 64'(mul_up_valid), 64'h1);
    chk("single_mula", mul_a, 64'h4000000000000000);
    chk("single_mulb", mul_b, 64'h4008000000000000);
    chk("single_busy", 64'(idle), 64'h0);
    adv(); mon();
    chk("single_upv_off", 64'(mul_up_valid), 64'h0);
    chk("single_mula_hold", mul_a, 64'h4000000000000000);
    while (cyc < c0 + 1 + L) begin
      adv(); mon();
      if (cyc < c0 + 1 + L) chk("single_rsp_early", 64'(rsp_vld), 64'h0);
    end
    chk("single_rsp", 64'(rsp_vld), 64'h1);
    chk("single_data", rsp_data, 64'h4018000000000000);
    adv(); mon();
    chk("single_rsp_once", 64'(rsp_vld), 64'h0);
    chk("single_idle", 64'(idle), 64'h1);

    // Four requesters held: 0,1,2,3,0,1,2,3 starting from a fresh pointer
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, real'(i + 1), 2.5);
    for (int k = 0; k < 8; k++) begin
      adv(); req_vld = '1; mon();
      chk("rr4_gnt", 64'(req_rdy), 64'(1) << (k % 4));
      if (k > 0) chk("rr4_upv", 64'(mul_up_valid), 64'h1);
    end
    adv(); req_vld = '0; mon();
    chk("rr4_upv_last", 64'(mul_up_valid), 64'h1);
    repeat (L + 2) begin adv(); mon(); end
    chk("rr4_drain", 64'(q_idx.size()), 64'h0);

    // Requesters 1 and 3 only: alternate with no bubbles
    for (int k = 0; k < 8; k++) begin
      adv(); req_vld = 4'b1010; mon();
      chk("rr2_gnt", 64'(req_rdy), (k % 2 == 0) ? 64'h2 : 64'h8);
      if (k > 0) chk("rr2_upv", 64'(mul_up_valid), 64'h1);
    end
    adv(); req_vld = '0; mon();
    repeat (L + 2) begin adv(); mon(); end
    chk("rr2_drain", 64'(q_idx.size()), 64'h0);

    // Reset with three operations in flight
    for (int k = 0; k < 3; k++) begin adv(); req_vld = '1; mon(); end
    adv(); req_vld = '0; mon();
    adv(); rst = 1'b0; req_vld = '1; #1;
    chk("mid_rst_rdy", 64'(req_rdy), 64'h0);
    chk("mid_rst_upv", 64'(mul_up_valid), 64'h0);
    chk("mid_rst_mula", mul_a, 64'h0);
    chk("mid_rst_mulb", mul_b, 64'h0);
    chk("mid_rst_idle", 64'(idle), 64'h1);
    chk("mid_rst_rsp", 64'(rsp_vld), 64'h0);
    chk("mid_rst_err", 64'(err), 64'h0);
    clear_sb();
    adv(); rst = 1'b1; req_vld = '0; mon();
    chk("stale_rsp0", 64'(rsp_vld), 64'h0);
    adv(); mon();
    chk("stale_err", 64'(err), 64'h1);
    chk("stale_rsp1", 64'(rsp_vld), 64'h0);
    repeat (4) begin adv(); mon(); end
    chk("stale_err_sticky", 64'(err), 64'h1);
    chk("stale_idle", 64'(idle), 64'h1);

    // Forced down_valid with an empty tag pipeline
    do_reset();
    adv(); mon();
    chk("force_pre_err", 64'(err), 64'h0);
    adv(); force_dv = 1'b1; mon();
    chk("force_rsp", 64'(rsp_vld), 64'h0);
    adv(); force_dv = 1'b0; mon();
    chk("force_err", 64'(err), 64'h1);
    repeat (3) begin adv(); mon(); end
    chk("force_err_sticky", 64'(err), 64'h1);

    // Random traffic against the behavioural multiplier
    do_reset();
    for (int k = 0; k < 10000; k++) begin
      adv();
      req_vld = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++)
        set_op(i, real'($urandom_range(0, 4000)) / 16.0, real'($urandom_range(0, 4000)) / 8.0);
      mon();
    end
    adv(); req_vld = '0; mon();
    repeat (L + 3) begin adv(); mon(); end
    chk("rand_all_answered", 64'(q_idx.size()), 64'h0);
    chk("rand_err", 64'(err), 64'h0);
    chk("rand_idle", 64'(idle), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
